sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_pkg.sv | 30 +++
 rtl/sram_controller.sv | 125 ++++++++++++
 tb/tb_sram_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants and types for the SRAM data-memory controller.
// Holds the FSM state encoding and the default memory-map/timing values.
package sram_controller_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int SRAM_DATA_WIDTH     = 16;
  localparam int SRAM_ADDR_WIDTH     = 18;
  localparam int SRAM_INDEX_WIDTH    = 17;
  localparam int WAIT_CNT_WIDTH      = 8;

  localparam int SRAM_BASE_DEFAULT   = 1024;
  localparam int WAIT_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    WAIT,
    DONE
  } sram_state_e;

  // Word offset from the SRAM window base; wraps modulo 2^17 words.
  function automatic logic [SRAM_INDEX_WIDTH-1:0] word_index(
    input logic [DATA_WIDTH-1:0] address,
    input logic [DATA_WIDTH-1:0] base
  );
    return SRAM_INDEX_WIDTH'((address - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit memory-stage access into two 16-bit SRAM cycles,
// then idles the bus for WAIT_CYCLES before signalling ready.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int SRAM_BASE   = SRAM_BASE_DEFAULT,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  sram_state_e                 state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic                        is_write_q, is_write_d;
  logic [DATA_WIDTH-1:0]       read_data_q, read_data_d;
  logic                        we_n_q, we_n_d;
  logic [SRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [SRAM_DATA_WIDTH-1:0]  dq_out_q, dq_out_d;
  logic [SRAM_INDEX_WIDTH-1:0] index;

  assign index = word_index(address, DATA_WIDTH'(SRAM_BASE));

  // Bus outputs are computed for the state being entered so they are
  // registered and stable for the whole SRAM cycle.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    is_write_d  = is_write_q;
    read_data_d = read_data_q;
    we_n_d      = 1'b1;
    addr_d      = '0;
    dq_out_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (wr_en || rd_en) begin
          state_d    = ACC_LO;
          is_write_d = wr_en;
          we_n_d     = ~wr_en;
          addr_d     = {index, 1'b0};
          dq_out_d   = write_data[15:0];
        end
      end
      ACC_LO: begin
        state_d  = ACC_HI;
        we_n_d   = ~is_write_q;
        addr_d   = {index, 1'b1};
        dq_out_d = write_data[31:16];
        if (!is_write_q) begin
          read_data_d[15:0] = SRAM_DQ;
        end
      end
      ACC_HI: begin
        if (!is_write_q) begin
          read_data_d[31:16] = SRAM_DQ;
        end
        if (WAIT_CYCLES == 0) begin
          state_d = DONE;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_CNT_WIDTH'(WAIT_CYCLES - 1);
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      is_write_q  <= 1'b0;
      read_data_q <= '0;
      we_n_q      <= 1'b1;
      addr_q      <= '0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
      we_n_q      <= we_n_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign ready     = ((state_q == IDLE) && !wr_en && !rd_en) || (state_q == DONE);
  assign read_data = read_data_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = we_n_q ? 16'bz : dq_out_q;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: a behavioural SRAM on the pins
// plus a word-level reference memory that predicts every observed value.
module tb_sram_controller;

  localparam int SRAM_BASE   = 1024;
  localparam int WAIT_CYCLES = 2;
  localparam int LATENCY     = 3 + WAIT_CYCLES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;

  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n, sram_we_n;

  bit   [15:0] sram_mem [0:262143];
  bit   [31:0] ref_mem [int];
  logic [31:0] exp_read_data = '0;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  sram_controller #(
    .SRAM_BASE   (SRAM_BASE),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_OE_N  (sram_oe_n),
    .SRAM_WE_N  (sram_we_n)
  );

  // Asynchronous SRAM: outputs the addressed half-word whenever not writing.
  assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 16'bz;

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [16:0] ref_index(input logic [31:0] a);
    int unsigned offset;
    offset = a - SRAM_BASE;
    return 17'((offset / 4) % 131072);
  endfunction

  function automatic logic [31:0] ref_word(input logic [16:0] idx);
    return ref_mem.exists(int'(idx)) ? ref_mem[int'(idx)] : 32'h0;
  endfunction

  task automatic apply_stimulus(input bit w, input bit r, input logic [31:0] a,
                                input logic [31:0] d);
    wr_en      = w;
    rd_en      = r;
    address    = a;
    write_data = d;
  endtask

  task automatic idle_cycle(input string name);
    logic [16:0] idx0;
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, address, write_data);
    #1;
    idx0 = 17'd0;
    check_output({name, "_ready"}, 32'(ready), 32'd1);
    check_output({name, "_we_n"}, 32'(sram_we_n), 32'd1);
    check_output({name, "_dq_released"}, 32'(sram_dq), 32'(ref_word(idx0) & 32'hFFFF));
  endtask

  // Starts in an IDLE cycle and ends in the DONE cycle with requests held.
  task automatic run_access(input string name, input bit w, input bit r,
                            input logic [31:0] a, input logic [31:0] d);
    bit          is_wr;
    logic [16:0] idx;
    is_wr = w;
    idx   = ref_index(a);
    @(negedge clk);
    apply_stimulus(w, r, a, d);
    #1;
    check_output($sformatf("%s_c0_ready", name), 32'(ready), 32'd0);
    if (is_wr) ref_mem[int'(idx)] = d;
    else exp_read_data = ref_word(idx);
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("%s_c%0d_ready", name, k), 32'(ready), 32'(k == LATENCY));
      if (k == 1 || k == 2) begin
        check_output($sformatf("%s_c%0d_addr", name, k), 32'(sram_addr),
                     32'({idx, (k == 2) ? 1'b1 : 1'b0}));
        check_output($sformatf("%s_c%0d_we_n", name, k), 32'(sram_we_n), 32'(!is_wr));
        if (is_wr) begin
          check_output($sformatf("%s_c%0d_dq", name, k), 32'(sram_dq),
                       (k == 1) ? 32'(d[15:0]) : 32'(d[31:16]));
        end
      end else begin
        check_output($sformatf("%s_c%0d_addr", name, k), 32'(sram_addr), 32'd0);
        check_output($sformatf("%s_c%0d_we_n", name, k), 32'(sram_we_n), 32'd1);
      end
      if (k == LATENCY) begin
        check_output($sformatf("%s_read_data", name), read_data, exp_read_data);
      end
    end
  endtask

  initial begin
    bit [1:0]    kind;
    logic [31:0] a, d;

    $display("[TB] start");
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("reset_ready", 32'(ready), 32'd1);
    check_output("reset_we_n", 32'(sram_we_n), 32'd1);
    check_output("reset_addr", 32'(sram_addr), 32'd0);
    check_output("reset_read_data", read_data, 32'd0);
    idle_cycle("idle0");
    idle_cycle("idle1");

    run_access("wr1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    idle_cycle("idle2");
    run_access("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0);
    idle_cycle("idle3");

    run_access("wr1028", 1'b1, 1'b0, 32'd1028, 32'h12345678);
    run_access("rd1028", 1'b0, 1'b1, 32'd1028, 32'h0);

    run_access("both1032", 1'b1, 1'b1, 32'd1032, 32'h0000A5A5);
    run_access("rd1032", 1'b0, 1'b1, 32'd1032, 32'h0);

    run_access("wr_below_base", 1'b1, 1'b0, 32'd1020, 32'hCAFEF00D);
    run_access("rd_below_base", 1'b0, 1'b1, 32'd1020, 32'h0);
    run_access("wr_wrap", 1'b1, 1'b0, 32'd1024 + 32'd524288 + 32'd8, 32'h0BADC0DE);
    run_access("rd_wrap_alias", 1'b0, 1'b1, 32'd1032, 32'h0);
    idle_cycle("idle4");

    // Reset while a read sits in its high half-word cycle.
    @(negedge clk);
    apply_stimulus(1'b0, 1'b1, 32'd1028, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("abort_read_data", read_data, 32'd0);
    check_output("abort_we_n", 32'(sram_we_n), 32'd1);
    check_output("abort_addr", 32'(sram_addr), 32'd0);
    check_output("abort_ready_req_held", 32'(ready), 32'd0);
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'd1028, 32'h0);
    exp_read_data = 32'h0;
    #1;
    check_output("abort_ready_released", 32'(ready), 32'd1);
    idle_cycle("idle5");
    run_access("rd_after_abort", 1'b0, 1'b1, 32'd1028, 32'h0);

    for (int i = 0; i < 40; i++) begin
      kind = 2'($urandom_range(0, 2));
      a    = 32'(SRAM_BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d    = $urandom;
      run_access($sformatf("rnd%0d", i), kind != 2'd1, kind != 2'd0, a, d);
      if ($urandom_range(0, 3) == 0) idle_cycle($sformatf("rnd_idle%0d", i));
    end
    idle_cycle("idle_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
